// File: rtl/usb_uart_buffered_if.sv
// rtl/usb_uart_buffered_if.sv - fabric-side and core-side signal bundles for usb_uart_buffered
interface usb_uart_fab_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_afull;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_afull, rx_data, rx_valid
  );
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_afull, rx_data, rx_valid
  );
endinterface

interface usb_uart_core_if;
  logic       core_wr;
  logic [7:0] core_tx_data;
  logic       core_busy;
  logic       core_rd;
  logic [7:0] core_rx_data;
  logic       core_valid;

  modport master (
    output core_wr, core_tx_data, core_rd,
    input  core_busy, core_rx_data, core_valid
  );
  modport slave (
    input  core_wr, core_tx_data, core_rd,
    output core_busy, core_rx_data, core_valid
  );
endinterface

// File: rtl/usb_uart_buffered.sv
// rtl/usb_uart_buffered.sv - TX/RX FIFO buffering and strobe pacing in front of usb_uart_core
// Optional level/drop statistics ports are enabled by defining USB_UART_BUFFERED_STATS_EN.
module usb_uart_buffered #(
  parameter int TX_AW    = 4,
  parameter int RX_AW    = 4,
  parameter int TX_AFULL = 2
) (
  input  logic            clk_48mhz,
  input  logic            reset,
  input  logic            host_presence,
  usb_uart_fab_if.slave   fab,
  usb_uart_core_if.master core
`ifdef USB_UART_BUFFERED_STATS_EN
  ,
  output logic [TX_AW:0]  tx_level,
  output logic [RX_AW:0]  rx_level,
  output logic [15:0]     tx_drop_cnt
`endif
);

  localparam int TX_DEPTH = 2 ** TX_AW;
  localparam int RX_DEPTH = 2 ** RX_AW;
  localparam logic [TX_AW:0] TX_FULL_CNT  = (TX_AW+1)'(TX_DEPTH);
  localparam logic [TX_AW:0] TX_AFULL_CNT = (TX_AW+1)'(TX_AFULL);
  localparam logic [RX_AW:0] RX_FULL_CNT  = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_HOLD} strobe_state_t;

  // ---------------- TX path ----------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count, tx_count_nxt;
  logic [7:0]       tx_head_q;
  logic             tx_afull_q;
  logic             hp_low_q;
  logic             tx_full, tx_empty, tx_accept, tx_push, tx_discard, tx_flush, tx_pop;
  strobe_state_t    tx_state, tx_state_nxt;

  assign tx_full    = (tx_count == TX_FULL_CNT);
  assign tx_empty   = (tx_count == '0);
  assign fab.tx_ready = !reset && (!tx_full || !host_presence);
  assign tx_accept  = fab.tx_valid && fab.tx_ready;
  assign tx_push    = tx_accept && host_presence;
  assign tx_discard = tx_accept && !host_presence;
  // Second consecutive low cycle of host_presence empties the queue.
  assign tx_flush   = !host_presence && hp_low_q;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty && host_presence && !core.core_busy) begin
          tx_pop       = 1'b1;
          tx_state_nxt = S_STROBE;
        end
      end
      S_STROBE: tx_state_nxt = S_HOLD;
      S_HOLD:   tx_state_nxt = S_IDLE;
      default:  tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) tx_state <= S_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_count_nxt = tx_count;
    if (tx_flush) begin
      tx_count_nxt = '0;
    end else begin
      case ({tx_push, tx_pop})
        2'b10:   tx_count_nxt = tx_count + (TX_AW+1)'(1);
        2'b01:   tx_count_nxt = tx_count - (TX_AW+1)'(1);
        default: tx_count_nxt = tx_count;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= fab.tx_data;
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      tx_head_q  <= 8'h00;
      tx_afull_q <= 1'b0;
      hp_low_q   <= 1'b0;
    end else begin
      hp_low_q   <= !host_presence;
      tx_count   <= tx_count_nxt;
      tx_afull_q <= (TX_FULL_CNT - tx_count_nxt) <= TX_AFULL_CNT;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop) begin
        tx_head_q <= tx_mem[tx_rd_ptr];
        tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      end
      if (tx_flush) tx_rd_ptr <= tx_wr_ptr;
    end
  end

  assign fab.tx_afull      = tx_afull_q && host_presence;
  assign core.core_wr      = (tx_state == S_STROBE);
  assign core.core_tx_data = tx_head_q;

  // ---------------- RX path ----------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  strobe_state_t    rx_state, rx_state_nxt;

  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_pop   = fab.rx_valid && fab.rx_ready;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_push      = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (core.core_valid && !rx_full) begin
          rx_push      = 1'b1;
          rx_state_nxt = S_STROBE;
        end
      end
      S_STROBE: rx_state_nxt = S_HOLD;
      S_HOLD:   rx_state_nxt = S_IDLE;
      default:  rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) rx_state <= S_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_ff @(posedge clk_48mhz) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= core.core_rx_data;
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  assign fab.rx_valid = !rx_empty;
  assign fab.rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
  assign core.core_rd = (rx_state == S_STROBE);

`ifdef USB_UART_BUFFERED_STATS_EN
  logic [15:0] drop_q;
  logic [16:0] drop_sum;

  // Flushed bytes and host-absent pushes both count as drops; never wraps.
  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(tx_discard) + (tx_flush ? 17'(tx_count) : 17'd0);
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) drop_q <= 16'h0000;
    else       drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign tx_level    = tx_count;
  assign rx_level    = rx_count;
  assign tx_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_usb_uart_buffered.sv
// tb/tb_usb_uart_buffered.sv - directed self-checking bench for usb_uart_buffered (TX_AW=RX_AW=2)
module tb_usb_uart_buffered;
  logic clk_48mhz = 1'b0;
  logic reset;
  logic host_presence;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_uart_fab_if  fab_i ();
  usb_uart_core_if core_i ();

`ifdef USB_UART_BUFFERED_STATS_EN
  logic [2:0]  tx_level;
  logic [2:0]  rx_level;
  logic [15:0] tx_drop_cnt;
`endif

  usb_uart_buffered #(.TX_AW(2), .RX_AW(2), .TX_AFULL(2)) dut (
    .clk_48mhz     (clk_48mhz),
    .reset         (reset),
    .host_presence (host_presence),
    .fab           (fab_i),
    .core          (core_i)
`ifdef USB_UART_BUFFERED_STATS_EN
    ,
    .tx_level      (tx_level),
    .rx_level      (rx_level),
    .tx_drop_cnt   (tx_drop_cnt)
`endif
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rd_cnt = 0;
  int         idx;
  bit         tx_acc;
  logic [7:0] rx_src [$];
  logic [7:0] tx_out [$];
  logic [7:0] rx_out [$];
  int         wr_cyc [$];
  logic [7:0] tx_vec [100];
  logic [7:0] rx_vec [100];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural core: holds queued bytes, drops the head on each core_rd.
  task automatic present();
    core_i.core_valid   = (rx_src.size() != 0);
    core_i.core_rx_data = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
  endtask

  task automatic tick();
    present();
    #2;
    tx_acc = fab_i.tx_valid && fab_i.tx_ready;
    if (fab_i.rx_valid && fab_i.rx_ready) rx_out.push_back(fab_i.rx_data);
    @(posedge clk_48mhz);
    #1;
    cyc++;
    if (core_i.core_wr) begin
      tx_out.push_back(core_i.core_tx_data);
      wr_cyc.push_back(cyc);
    end
    if (core_i.core_rd) begin
      rd_cnt++;
      if (rx_src.size() != 0) void'(rx_src.pop_front());
    end
    present();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    host_presence = 1'b1;
    fab_i.tx_valid = 1'b0;
    fab_i.tx_data  = 8'h00;
    fab_i.rx_ready = 1'b0;
    core_i.core_busy = 1'b0;
    present();
    @(posedge clk_48mhz);
    #1;
    check("ready_in_reset", fab_i.tx_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_tx_ready", fab_i.tx_ready, 1);
    check("rst_tx_afull", fab_i.tx_afull, 0);
    check("rst_rx_valid", fab_i.rx_valid, 0);
    check("rst_rx_data", fab_i.rx_data, 0);
    check("rst_core_wr", core_i.core_wr, 0);
    check("rst_core_tx_data", core_i.core_tx_data, 0);
    check("rst_core_rd", core_i.core_rd, 0);

    // Loopback: three back-to-back bytes, strobes 3 cycles apart
    fab_i.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fab_i.tx_data = 8'h41 + 8'(i);
      tick();
      check("lb_ready", tx_acc, 1);
    end
    fab_i.tx_valid = 1'b0;
    for (int k = 0; k < 30 && tx_out.size() < 3; k++) tick();
    check("lb_count", tx_out.size(), 3);
    for (int i = 0; i < 3; i++) check("lb_data", tx_out[i], 8'h41 + 8'(i));
    check("lb_gap0", wr_cyc[1] - wr_cyc[0], 3);
    check("lb_gap1", wr_cyc[2] - wr_cyc[1], 3);

    // TX full with core busy, then drain
    repeat (4) tick();
    tx_out.delete();
    wr_cyc.delete();
    core_i.core_busy = 1'b1;
    fab_i.tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fab_i.tx_data = 8'h10 + 8'(i);
      tick();
      check("full_accept", tx_acc, (i < 4) ? 1 : 0);
      check("full_afull", fab_i.tx_afull, (i >= 1) ? 1 : 0);
    end
    fab_i.tx_valid = 1'b0;
    core_i.core_busy = 1'b0;
    tick();
    check("full_ready_back", fab_i.tx_ready, 1);
    check("full_first_wr", core_i.core_wr, 1);
    for (int k = 0; k < 40 && tx_out.size() < 4; k++) tick();
    check("full_count", tx_out.size(), 4);
    for (int i = 0; i < 4; i++) check("full_data", tx_out[i], 8'h10 + 8'(i));

    // RX backpressure: 6 bytes offered, only 4 fit
    rd_cnt = 0;
    rx_out.delete();
    for (int i = 0; i < 6; i++) rx_src.push_back(8'hA0 + 8'(i));
    repeat (20) tick();
    check("bp_rd_pulses", rd_cnt, 4);
    check("bp_core_valid", core_i.core_valid, 1);
    check("bp_rx_valid", fab_i.rx_valid, 1);
    check("bp_rx_head", fab_i.rx_data, 8'hA0);
    fab_i.rx_ready = 1'b1;
    for (int k = 0; k < 100 && rx_out.size() < 6; k++) tick();
    fab_i.rx_ready = 1'b0;
    check("bp_count", rx_out.size(), 6);
    for (int i = 0; i < 6; i++) check("bp_data", rx_out[i], 8'hA0 + 8'(i));

    // Host detach: queued bytes flushed, later pushes discarded
    repeat (4) tick();
    tx_out.delete();
    core_i.core_busy = 1'b1;
    fab_i.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fab_i.tx_data = 8'h60 + 8'(i);
      tick();
    end
    fab_i.tx_valid = 1'b0;
    check("det_afull_before", fab_i.tx_afull, 1);
    host_presence = 1'b0;
    tick();
    check("det_afull_forced", fab_i.tx_afull, 0);
    tick();
`ifdef USB_UART_BUFFERED_STATS_EN
    check("det_level_flushed", tx_level, 0);
`endif
    fab_i.tx_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fab_i.tx_data = 8'h68 + 8'(i);
      tick();
      check("det_accept", tx_acc, 1);
    end
    fab_i.tx_valid = 1'b0;
`ifdef USB_UART_BUFFERED_STATS_EN
    check("det_drop_cnt", tx_drop_cnt, 5);
`endif
    host_presence = 1'b1;
    core_i.core_busy = 1'b0;
    repeat (15) tick();
    check("det_no_wr", tx_out.size(), 0);
    check("det_afull_after", fab_i.tx_afull, 0);

    // Reset during a TX strobe with bytes queued and an RX byte held
    core_i.core_busy = 1'b1;
    fab_i.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fab_i.tx_data = 8'h70 + 8'(i);
      tick();
    end
    fab_i.tx_valid = 1'b0;
    rx_src.push_back(8'hB0);
    rx_src.push_back(8'hB1);
    repeat (4) tick();
    check("mid_rx_pending", fab_i.rx_valid, 1);
    core_i.core_busy = 1'b0;
    tx_out.delete();
    tick();
    check("mid_in_strobe", core_i.core_wr, 1);
    reset = 1'b1;
    #1;
    check("mid_ready_in_reset", fab_i.tx_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_tx_ready", fab_i.tx_ready, 1);
    check("mid_tx_afull", fab_i.tx_afull, 0);
    check("mid_rx_valid", fab_i.rx_valid, 0);
    check("mid_rx_data", fab_i.rx_data, 0);
    check("mid_core_wr", core_i.core_wr, 0);
    check("mid_core_tx_data", core_i.core_tx_data, 0);
    check("mid_core_rd", core_i.core_rd, 0);
`ifdef USB_UART_BUFFERED_STATS_EN
    check("mid_drop_clr", tx_drop_cnt, 0);
`endif
    rx_src.delete();
    tx_out.delete();
    rd_cnt = 0;
    repeat (10) tick();
    check("mid_no_wr", tx_out.size(), 0);
    check("mid_no_rd", rd_cnt, 0);
    check("mid_rx_empty", fab_i.rx_valid, 0);

    // Wrap-around stream with random handshakes
    tx_out.delete();
    rx_out.delete();
    for (int i = 0; i < 100; i++) begin
      tx_vec[i] = 8'(i * 7 + 3);
      rx_vec[i] = 8'(i) ^ 8'h5A;
      rx_src.push_back(rx_vec[i]);
    end
    idx = 0;
    for (int k = 0; k < 4000 && (tx_out.size() < 100 || rx_out.size() < 100); k++) begin
      fab_i.tx_valid   = (idx < 100) && ($urandom_range(0, 1) == 1);
      fab_i.tx_data    = tx_vec[(idx < 100) ? idx : 0];
      fab_i.rx_ready   = ($urandom_range(0, 1) == 1);
      core_i.core_busy = ($urandom_range(0, 3) == 0);
      tick();
      if (tx_acc) idx++;
    end
    fab_i.tx_valid = 1'b0;
    fab_i.rx_ready = 1'b0;
    core_i.core_busy = 1'b0;
    repeat (6) tick();
    check("wrap_tx_count", tx_out.size(), 100);
    check("wrap_rx_count", rx_out.size(), 100);
    for (int i = 0; i < 100; i++) begin
      check("wrap_tx_data", tx_out[i], tx_vec[i]);
      check("wrap_rx_data", rx_out[i], rx_vec[i]);
    end
    check("wrap_rx_valid", fab_i.rx_valid, 0);
    check("wrap_tx_afull", fab_i.tx_afull, 0);
`ifdef USB_UART_BUFFERED_STATS_EN
    check("wrap_tx_level", tx_level, 0);
    check("wrap_rx_level", rx_level, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
